// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Holds the default datapath width, the buffered fetch entry and the pointer-width helper.
package ifq_pkg;

    localparam int IFQ_XLEN = 32;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] data;
        logic [IFQ_XLEN-1:0] pc;
    } fetch_entry_t;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, synchronous flush and occupancy count.
// Storage is cleared on reset so the head output is defined before the first push.
module sync_fifo
    import ifq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue: issues PC addresses to instruction memory, tags responses with their PC, buffers for decode.
// IFQ_BYPASS_EN: when defined, a response into an empty queue goes straight to decode in the same cycle.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = IFQ_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc_addr,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins_data,
    output logic [XLEN-1:0] ins_pc,
    input  logic            ins_ready
);
    localparam int PW = ptr_width(DEPTH);

    logic            awake;
    logic [PW-1:0]   discard;
    logic [PW-1:0]   tag_count;
    logic [PW-1:0]   data_count;
    logic [PW-1:0]   in_flight;
    logic            tag_full, tag_empty, data_full, data_empty;
    logic [XLEN-1:0] tag_head;
    fetch_entry_t    data_in, data_head;
    logic            credit, grant, live_rsp, bypass, data_push, data_pop;

    // Live requests sit in the tag FIFO; flushed ones are only counted by discard.
    assign in_flight = tag_count + discard;
    assign credit    = (in_flight + data_count < PW'(DEPTH)) && !tag_full && !data_full;

    assign imem_req  = awake && pc_valid && credit && !flush;
    assign imem_addr = pc_addr;
    assign grant     = imem_req && imem_gnt;
    assign pc_ready  = grant;

    assign live_rsp  = imem_rvalid && (discard == '0) && !tag_empty && !flush;

`ifdef IFQ_BYPASS_EN
    assign bypass    = live_rsp && data_empty && ins_ready;
`else
    assign bypass    = 1'b0;
`endif

    assign data_in   = '{data: imem_rdata, pc: tag_head};
    assign data_push = live_rsp && !bypass;
    assign data_pop  = ins_valid && ins_ready;

    assign ins_valid = !data_empty || bypass;
    assign ins_data  = bypass ? imem_rdata : data_head.data;
    assign ins_pc    = bypass ? tag_head   : data_head.pc;

    // awake keeps requests off until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awake   <= 1'b0;
            discard <= '0;
        end else begin
            awake <= 1'b1;
            if (flush)
                discard <= in_flight - PW'(imem_rvalid && (in_flight != '0));
            else if (imem_rvalid && (discard != '0))
                discard <= discard - 1'b1;
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .wdata (pc_addr),
        .pop   (live_rsp),
        .flush (flush),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_push),
        .wdata (data_in),
        .pop   (data_pop),
        .flush (flush),
        .rdata (data_head),
        .full  (data_full),
        .empty (data_empty),
        .count (data_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, XLEN=32).
// Memory responses are driven by hand; expected values are written out per cycle.
module tb_instr_fetch_queue;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_valid    (pc_valid),
        .pc_addr     (pc_addr),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; flush = 1'b0; ins_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL reset_ins_valid got %b want 0", ins_valid); end
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL reset_pc_ready got %b want 0", pc_ready); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
        n_cmp++; if (ins_data !== 32'h0) begin n_err++; $display("FAIL reset_ins_data got %h want 0", ins_data); end
        n_cmp++; if (ins_pc !== 32'h0) begin n_err++; $display("FAIL reset_ins_pc got %h want 0", ins_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        bit          exp_v;
        logic [31:0] exp_pc;
        for (int c = 0; c < 6; c++) begin
            pc_valid = (c < 4); pc_addr = 32'(4 * c); imem_gnt = 1'b1; ins_ready = 1'b1;
            imem_rvalid = (c >= 1 && c <= 4); imem_rdata = 32'h1000_0000 | 32'(4 * (c - 1));
            #3;
            n_cmp++; if (pc_ready !== (c < 4)) begin n_err++; $display("FAIL stream_pc_ready c=%0d got %b want %b", c, pc_ready, (c < 4)); end
            exp_v  = BYP ? (c >= 1 && c <= 4) : (c >= 2 && c <= 5);
            exp_pc = BYP ? 32'(4 * (c - 1)) : 32'(4 * (c - 2));
            n_cmp++; if (ins_valid !== exp_v) begin n_err++; $display("FAIL stream_ins_valid c=%0d got %b want %b", c, ins_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (ins_pc !== exp_pc) begin n_err++; $display("FAIL stream_ins_pc c=%0d got %h want %h", c, ins_pc, exp_pc); end
                n_cmp++; if (ins_data !== (32'h1000_0000 | exp_pc)) begin n_err++; $display("FAIL stream_ins_data c=%0d got %h want %h", c, ins_data, 32'h1000_0000 | exp_pc); end
            end
            step();
        end
        idle();
    endtask

    task automatic test_backpressure();
        bit exp_r [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit rv    [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int i = 0;
        logic [31:0] exp_pc;
        for (int c = 0; c < 6; c++) begin
            pc_valid = 1'b1; pc_addr = 32'h40 + 32'(4 * i); imem_gnt = 1'b1; ins_ready = 1'b0;
            imem_rvalid = rv[c]; imem_rdata = 32'h1000_0000 | (32'h40 + 32'(4 * (c - 1)));
            #3;
            n_cmp++; if (pc_ready !== exp_r[c]) begin n_err++; $display("FAIL bp_pc_ready c=%0d got %b want %b", c, pc_ready, exp_r[c]); end
            if (c == 4) begin
                n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_imem_req_full got %b want 0", imem_req); end
            end
            if (exp_r[c]) i++;
            step();
        end
        pc_valid = 1'b1; pc_addr = 32'h50; imem_rvalid = 1'b0; ins_ready = 1'b1;
        #3;
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL bp_pop_cycle_pc_ready got %b want 0", pc_ready); end
        n_cmp++; if (ins_pc !== 32'h40) begin n_err++; $display("FAIL bp_head_pc got %h want 00000040", ins_pc); end
        step();
        ins_ready = 1'b0;
        #3;
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL bp_credit_return got %b want 1", pc_ready); end
        step();
        pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0050;
        step();
        imem_rvalid = 1'b0; ins_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            exp_pc = 32'h44 + 32'(4 * k);
            n_cmp++; if (ins_valid !== (k < 4)) begin n_err++; $display("FAIL bp_drain_valid k=%0d got %b want %b", k, ins_valid, (k < 4)); end
            if (k < 4) begin
                n_cmp++; if (ins_pc !== exp_pc) begin n_err++; $display("FAIL bp_drain_pc k=%0d got %h want %h", k, ins_pc, exp_pc); end
                n_cmp++; if (ins_data !== (32'h1000_0000 | exp_pc)) begin n_err++; $display("FAIL bp_drain_data k=%0d got %h want %h", k, ins_data, 32'h1000_0000 | exp_pc); end
            end
            step();
        end
        idle();
    endtask

    task automatic test_gnt_stall();
        for (int c = 0; c < 3; c++) begin
            pc_valid = 1'b1; pc_addr = 32'h100; imem_gnt = 1'b0;
            #3;
            n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req c=%0d got %b want 1", c, imem_req); end
            n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL stall_addr c=%0d got %h want 00000100", c, imem_addr); end
            n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL stall_pc_ready c=%0d got %b want 0", c, pc_ready); end
            step();
        end
        imem_gnt = 1'b1;
        #3;
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept got %b want 1", pc_ready); end
        step();
        pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0100; ins_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_cmp++; if (ins_valid !== (BYP == (c == 0))) begin n_err++; $display("FAIL stall_latency c=%0d got %b want %b", c, ins_valid, (BYP == (c == 0))); end
            if (BYP == (c == 0)) begin
                n_cmp++; if (ins_pc !== 32'h100) begin n_err++; $display("FAIL stall_ins_pc got %h want 00000100", ins_pc); end
                n_cmp++; if (ins_data !== 32'h1000_0100) begin n_err++; $display("FAIL stall_ins_data got %h want 10000100", ins_data); end
            end
            step();
            imem_rvalid = 1'b0;
        end
        idle();
    endtask

    task automatic test_flush();
        logic [31:0] addrs [3] = '{32'h300, 32'h304, 32'h308};
        for (int c = 0; c < 3; c++) begin
            pc_valid = 1'b1; pc_addr = addrs[c]; imem_gnt = 1'b1; ins_ready = 1'b0;
            imem_rvalid = (c == 1); imem_rdata = 32'h1000_0300;
            step();
        end
        flush = 1'b1; pc_addr = 32'h200; imem_rvalid = 1'b0; ins_ready = 1'b1;
        #3;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL flush_req_suppressed got %b want 0", imem_req); end
        n_cmp++; if (ins_pc !== 32'h300) begin n_err++; $display("FAIL flush_head_before got %h want 00000300", ins_pc); end
        step();
        flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
        #3;
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL flush_buffer_gone got %b want 0", ins_valid); end
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL flush_redirect_accept got %b want 1", pc_ready); end
        step();
        pc_valid = 1'b0; imem_gnt = 1'b0; imem_rdata = 32'hDEAD_0001;
        #3;
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL flush_second_drop got %b want 0", ins_valid); end
        step();
        imem_rdata = 32'h1000_0200;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_cmp++; if (ins_valid !== (BYP == (c == 0))) begin n_err++; $display("FAIL flush_new_valid c=%0d got %b want %b", c, ins_valid, (BYP == (c == 0))); end
            if (BYP == (c == 0)) begin
                n_cmp++; if (ins_pc !== 32'h200) begin n_err++; $display("FAIL flush_new_pc got %h want 00000200", ins_pc); end
                n_cmp++; if (ins_data !== 32'h1000_0200) begin n_err++; $display("FAIL flush_new_data got %h want 10000200", ins_data); end
            end
            step();
            imem_rvalid = 1'b0;
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] addrs [3] = '{32'h400, 32'h404, 32'h408};
        for (int c = 0; c < 3; c++) begin
            pc_valid = 1'b1; pc_addr = addrs[c]; imem_gnt = 1'b1; ins_ready = 1'b0;
            imem_rvalid = (c == 1); imem_rdata = 32'h1000_0400;
            step();
        end
        pc_addr = 32'h40C; imem_rvalid = 1'b0;
        #1;
        n_cmp++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL midrst_before got %b want 1", ins_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ins_valid got %b want 0", ins_valid); end
        n_cmp++; if (pc_ready !== 1'b0) begin n_err++; $display("FAIL midrst_pc_ready got %b want 0", pc_ready); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_imem_req got %b want 0", imem_req); end
        @(negedge clk);
        rst_n = 1'b1; pc_valid = 1'b0; imem_gnt = 1'b0;
        step();
        pc_valid = 1'b1; pc_addr = 32'h0; imem_gnt = 1'b1;
        #3;
        n_cmp++; if (pc_ready !== 1'b1) begin n_err++; $display("FAIL midrst_refetch got %b want 1", pc_ready); end
        step();
        pc_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1000_0000; ins_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #3;
            n_cmp++; if (ins_valid !== (BYP == (c == 0))) begin n_err++; $display("FAIL midrst_valid c=%0d got %b want %b", c, ins_valid, (BYP == (c == 0))); end
            if (BYP == (c == 0)) begin
                n_cmp++; if (ins_pc !== 32'h0) begin n_err++; $display("FAIL midrst_ins_pc got %h want 00000000", ins_pc); end
                n_cmp++; if (ins_data !== 32'h1000_0000) begin n_err++; $display("FAIL midrst_ins_data got %h want 10000000", ins_data); end
            end
            step();
            imem_rvalid = 1'b0;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_gnt_stall();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
